// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types, arbitration-mode constants and index-width helper.
// Revision : 1.0
// ============================================================================
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   // Smallest w with 2**w >= value.
   function automatic int clog2(input int value);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) w = i + 1;
      end
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter_if
// Brief    : Requester-side and memory-side signals of the shared bus arbiter.
// Revision : 1.0
// ============================================================================
interface mem_bus_arbiter_if #(
   parameter int NUM_REQ = 3,
   parameter int ADR_W   = 32,
   parameter int DATA_W  = 32
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_we;
   logic [NUM_REQ-1:0]        req_w;
   logic [NUM_REQ-1:0]        req_hw;
   logic [NUM_REQ*ADR_W-1:0]  req_adr;
   logic [NUM_REQ*DATA_W-1:0] req_wdata;
   logic [NUM_REQ-1:0]        req_grant;
   logic [NUM_REQ-1:0]        rsp_done;
   logic [NUM_REQ-1:0]        rsp_err;
   logic [DATA_W-1:0]         rsp_rdata;
   logic                      busy;
   logic                      mem_read_req;
   logic                      mem_read_w;
   logic                      mem_read_hw;
   logic [ADR_W-1:0]          mem_read_adr;
   logic                      mem_read_valid;
   logic [DATA_W-1:0]         mem_read_data;
   logic                      mem_write_req;
   logic                      mem_write_w;
   logic                      mem_write_hw;
   logic [ADR_W-1:0]          mem_write_adr;
   logic [DATA_W-1:0]         mem_write_data;
   logic                      mem_write_finish;

   // Arbiter view
   modport master (
      input  req_valid, req_we, req_w, req_hw, req_adr, req_wdata,
      input  mem_read_valid, mem_read_data, mem_write_finish,
      output req_grant, rsp_done, rsp_err, rsp_rdata, busy,
      output mem_read_req, mem_read_w, mem_read_hw, mem_read_adr,
      output mem_write_req, mem_write_w, mem_write_hw, mem_write_adr, mem_write_data
   );

   // Requesters plus memory fabric view
   modport slave (
      output req_valid, req_we, req_w, req_hw, req_adr, req_wdata,
      output mem_read_valid, mem_read_data, mem_write_finish,
      input  req_grant, rsp_done, rsp_err, rsp_rdata, busy,
      input  mem_read_req, mem_read_w, mem_read_hw, mem_read_adr,
      input  mem_write_req, mem_write_w, mem_write_hw, mem_write_adr, mem_write_data
   );

endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter_picker.sv
`default_nettype none
// ============================================================================
// Module   : arb_picker
// Brief    : Combinational winner select, fixed priority or round-robin.
// Revision : 1.0
// ============================================================================
module arb_picker
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ  = 3,
   parameter int ARB_MODE = ARB_FIXED,
   parameter int IDX_W    = 2
) (
   input  wire logic [NUM_REQ-1:0] i_req,
   input  wire logic [IDX_W-1:0]   i_ptr,
   output logic      [NUM_REQ-1:0] o_grant,
   output logic      [IDX_W-1:0]   o_idx,
   output logic                    o_any
);

   // Search starts at 0 in fixed mode, or just past the last winner in RR mode.
   always_comb begin
      int start;
      int j;
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      start   = (ARB_MODE == ARB_RR) ? int'(i_ptr) + 1 : 0;
      j       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = (start + k) % NUM_REQ;
         if (!o_any && i_req[j]) begin
            o_any      = 1'b1;
            o_idx      = IDX_W'(j);
            o_grant[j] = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Brief    : N-requester single-outstanding arbiter for the shared memory bus.
// Revision : 1.0
// ============================================================================
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ  = 3,
   parameter int ADR_W    = 32,
   parameter int DATA_W   = 32,
   parameter int ARB_MODE = ARB_FIXED,
   parameter int TIMEOUT  = 255
) (
   input wire logic          clk,
   input wire logic          rst,
   mem_bus_arbiter_if.master bus
);

   localparam int C_IDX_W = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;
   localparam int C_CNT_W = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;

   state_t              r_state;
   logic [C_IDX_W-1:0]  r_ptr;
   logic [NUM_REQ-1:0]  r_owner;
   logic                r_we;
   logic                r_w;
   logic                r_hw;
   logic [ADR_W-1:0]    r_adr;
   logic [DATA_W-1:0]   r_wdata;
   logic [NUM_REQ-1:0]  r_grant;
   logic [NUM_REQ-1:0]  r_done;
   logic [NUM_REQ-1:0]  r_err;
   logic [DATA_W-1:0]   r_rdata;
   logic [C_CNT_W-1:0]  r_cnt;
   logic                r_rd_req;
   logic                r_wr_req;

   logic [NUM_REQ-1:0]  w_grant;
   logic [C_IDX_W-1:0]  w_idx;
   logic                w_any;
   logic                w_strobe;
   logic [C_CNT_W-1:0]  w_cnt_nxt;
   logic                w_timeout;

   arb_picker #(
      .NUM_REQ  (NUM_REQ),
      .ARB_MODE (ARB_MODE),
      .IDX_W    (C_IDX_W)
   ) u_picker (
      .i_req   (bus.req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   // Only the strobe matching the latched direction can complete the transfer.
   assign w_strobe  = r_we ? bus.mem_write_finish : bus.mem_read_valid;
   assign w_cnt_nxt = r_cnt + 1'b1;
   assign w_timeout = (TIMEOUT != 0) && (w_cnt_nxt == C_CNT_W'(TIMEOUT));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_ptr    <= C_IDX_W'(NUM_REQ - 1);
         r_owner  <= '0;
         r_we     <= 1'b0;
         r_w      <= 1'b0;
         r_hw     <= 1'b0;
         r_adr    <= '0;
         r_wdata  <= '0;
         r_grant  <= '0;
         r_done   <= '0;
         r_err    <= '0;
         r_rdata  <= '0;
         r_cnt    <= '0;
         r_rd_req <= 1'b0;
         r_wr_req <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= '0;
               r_err  <= '0;
               if (w_any) begin
                  r_state  <= WAIT;
                  r_grant  <= w_grant;
                  r_owner  <= w_grant;
                  r_ptr    <= w_idx;
                  r_we     <= bus.req_we[w_idx];
                  r_w      <= bus.req_w[w_idx];
                  r_hw     <= bus.req_hw[w_idx];
                  r_adr    <= bus.req_adr[int'(w_idx)*ADR_W +: ADR_W];
                  r_wdata  <= bus.req_wdata[int'(w_idx)*DATA_W +: DATA_W];
                  r_rd_req <= ~bus.req_we[w_idx];
                  r_wr_req <= bus.req_we[w_idx];
                  r_cnt    <= '0;
               end
            end
            WAIT: begin
               r_grant <= '0;
               r_cnt   <= w_cnt_nxt;
               // A completion coinciding with the timeout wins: no error.
               if (w_strobe) begin
                  r_state  <= RESP;
                  r_done   <= r_owner;
                  r_rdata  <= r_we ? '0 : bus.mem_read_data;
                  r_rd_req <= 1'b0;
                  r_wr_req <= 1'b0;
               end else if (w_timeout) begin
                  r_state  <= RESP;
                  r_done   <= r_owner;
                  r_err    <= r_owner;
                  r_rdata  <= '0;
                  r_rd_req <= 1'b0;
                  r_wr_req <= 1'b0;
               end
            end
            RESP: begin
               r_state <= IDLE;
               r_done  <= '0;
               r_err   <= '0;
               r_rdata <= '0;
               r_cnt   <= '0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.req_grant      = r_grant;
   assign bus.rsp_done       = r_done;
   assign bus.rsp_err        = r_err;
   assign bus.rsp_rdata      = r_rdata;
   assign bus.busy           = (r_state != IDLE);
   assign bus.mem_read_req   = r_rd_req;
   assign bus.mem_read_w     = r_w;
   assign bus.mem_read_hw    = r_hw;
   assign bus.mem_read_adr   = r_adr;
   assign bus.mem_write_req  = r_wr_req;
   assign bus.mem_write_w    = r_w;
   assign bus.mem_write_hw   = r_hw;
   assign bus.mem_write_adr  = r_adr;
   assign bus.mem_write_data = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Brief    : Directed self-checking bench; one fixed-priority and one RR arbiter.
// Revision : 1.0
// ============================================================================
module tb_mem_bus_arbiter;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [2:0] seen;
   logic [2:0] exp_oh;

   always #5 clk = ~clk;

   mem_bus_arbiter_if #(.NUM_REQ(3), .ADR_W(32), .DATA_W(32)) f_bus ();
   mem_bus_arbiter_if #(.NUM_REQ(3), .ADR_W(32), .DATA_W(32)) r_bus ();

   mem_bus_arbiter #(
      .NUM_REQ(3), .ADR_W(32), .DATA_W(32), .ARB_MODE(0), .TIMEOUT(4)
   ) u_fix (
      .clk (clk),
      .rst (rst),
      .bus (f_bus.master)
   );

   mem_bus_arbiter #(
      .NUM_REQ(3), .ADR_W(32), .DATA_W(32), .ARB_MODE(1), .TIMEOUT(4)
   ) u_rr (
      .clk (clk),
      .rst (rst),
      .bus (r_bus.master)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      f_bus.req_valid = '0; f_bus.req_we = '0; f_bus.req_w = '0; f_bus.req_hw = '0;
      f_bus.req_adr = '0; f_bus.req_wdata = '0;
      f_bus.mem_read_valid = 1'b0; f_bus.mem_read_data = '0; f_bus.mem_write_finish = 1'b0;
      r_bus.req_valid = '0; r_bus.req_we = '0; r_bus.req_w = '0; r_bus.req_hw = '0;
      r_bus.req_adr = '0; r_bus.req_wdata = '0;
      r_bus.mem_read_valid = 1'b0; r_bus.mem_read_data = '0; r_bus.mem_write_finish = 1'b0;
      step();
      step();
      rst = 1'b0;

      // Reset state
      chk("rst_grant", f_bus.req_grant, 3'b000);
      chk("rst_done", f_bus.rsp_done, 3'b000);
      chk("rst_busy", f_bus.busy, 1'b0);
      chk("rst_rd_req", f_bus.mem_read_req, 1'b0);
      chk("rst_wr_req", f_bus.mem_write_req, 1'b0);
      chk("rst_rr_busy", r_bus.busy, 1'b0);

      // Fixed mode read, req1 beats req2, strobe two cycles after grant
      f_bus.req_valid = 3'b110;
      f_bus.req_w = 3'b010;
      f_bus.req_adr[32 +: 32] = 32'h0000_0100;
      f_bus.req_adr[64 +: 32] = 32'h0000_0999;
      step();
      chk("t1_grant", f_bus.req_grant, 3'b010);
      chk("t1_rd_req", f_bus.mem_read_req, 1'b1);
      chk("t1_adr", f_bus.mem_read_adr, 32'h100);
      chk("t1_rd_w", f_bus.mem_read_w, 1'b1);
      chk("t1_busy", f_bus.busy, 1'b1);
      f_bus.req_valid = 3'b000;
      step();
      chk("t1_grant_pulse", f_bus.req_grant, 3'b000);
      chk("t1_hold_req", f_bus.mem_read_req, 1'b1);
      chk("t1_hold_adr", f_bus.mem_read_adr, 32'h100);
      f_bus.mem_read_valid = 1'b1;
      f_bus.mem_read_data = 32'hDEAD_BEEF;
      step();
      chk("t1_done", f_bus.rsp_done, 3'b010);
      chk("t1_rdata", f_bus.rsp_rdata, 32'hDEAD_BEEF);
      chk("t1_err", f_bus.rsp_err, 3'b000);
      chk("t1_rd_req_low", f_bus.mem_read_req, 1'b0);
      f_bus.mem_read_valid = 1'b0;
      f_bus.mem_read_data = '0;
      step();
      chk("t1_idle_busy", f_bus.busy, 1'b0);
      chk("t1_done_pulse", f_bus.rsp_done, 3'b000);

      // Fixed mode: req0 always beats req2
      f_bus.req_valid = 3'b101;
      f_bus.req_w = 3'b000;
      seen = '0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t3_grant", f_bus.req_grant, 3'b001);
         seen = seen | f_bus.req_grant;
         step();
         seen = seen | f_bus.req_grant;
         f_bus.mem_read_valid = 1'b1;
         step();
         chk("t3_done", f_bus.rsp_done, 3'b001);
         f_bus.mem_read_valid = 1'b0;
         if (i == 2) f_bus.req_valid = 3'b000;
         step();
         seen = seen | f_bus.req_grant;
      end
      chk("t3_req2_never", seen, 3'b001);

      // RR mode: rotation 0,1,2,0,1,2 with a grant every 4 cycles
      r_bus.req_valid = 3'b111;
      for (int i = 0; i < 6; i++) begin
         exp_oh = 3'b001 << (i % 3);
         step();
         chk("t2_grant", r_bus.req_grant, exp_oh);
         step();
         chk("t2_grant_pulse", r_bus.req_grant, 3'b000);
         r_bus.mem_read_valid = 1'b1;
         step();
         chk("t2_done", r_bus.rsp_done, exp_oh);
         r_bus.mem_read_valid = 1'b0;
         if (i == 5) r_bus.req_valid = 3'b000;
         step();
         chk("t2_idle", r_bus.busy, 1'b0);
      end

      // Write timeout after 4 wait cycles; a read strobe meanwhile is ignored
      f_bus.req_valid = 3'b001;
      f_bus.req_we = 3'b001;
      f_bus.req_w = 3'b001;
      f_bus.req_adr[0 +: 32] = 32'h0000_0200;
      f_bus.req_wdata[0 +: 32] = 32'h1234_5678;
      step();
      chk("t4_grant", f_bus.req_grant, 3'b001);
      chk("t4_wr_req", f_bus.mem_write_req, 1'b1);
      chk("t4_rd_req", f_bus.mem_read_req, 1'b0);
      chk("t4_wr_adr", f_bus.mem_write_adr, 32'h200);
      chk("t4_wr_data", f_bus.mem_write_data, 32'h1234_5678);
      f_bus.req_valid = 3'b000;
      f_bus.mem_read_valid = 1'b1;
      f_bus.mem_read_data = 32'h0000_FFFF;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t4_wr_req_held", f_bus.mem_write_req, 1'b1);
         chk("t4_no_done", f_bus.rsp_done, 3'b000);
      end
      step();
      chk("t4_done", f_bus.rsp_done, 3'b001);
      chk("t4_err", f_bus.rsp_err, 3'b001);
      chk("t4_rdata", f_bus.rsp_rdata, 32'h0);
      chk("t4_wr_req_low", f_bus.mem_write_req, 1'b0);
      f_bus.mem_read_valid = 1'b0;
      f_bus.mem_read_data = '0;
      step();
      chk("t4_busy_low", f_bus.busy, 1'b0);
      chk("t4_done_pulse", f_bus.rsp_done, 3'b000);

      // Write completes in the same cycle the counter reaches the limit
      f_bus.req_valid = 3'b100;
      f_bus.req_we = 3'b100;
      f_bus.req_w = 3'b000;
      f_bus.req_hw = 3'b100;
      f_bus.req_adr[64 +: 32] = 32'h0000_0300;
      f_bus.req_wdata[64 +: 32] = 32'h0000_A5A5;
      step();
      chk("t5_grant", f_bus.req_grant, 3'b100);
      chk("t5_wr_hw", f_bus.mem_write_hw, 1'b1);
      chk("t5_wr_w", f_bus.mem_write_w, 1'b0);
      chk("t5_wr_data", f_bus.mem_write_data, 32'h0000_A5A5);
      f_bus.req_valid = 3'b000;
      step();
      step();
      step();
      f_bus.mem_write_finish = 1'b1;
      step();
      chk("t5_done", f_bus.rsp_done, 3'b100);
      chk("t5_err", f_bus.rsp_err, 3'b000);
      chk("t5_rdata", f_bus.rsp_rdata, 32'h0);
      f_bus.mem_write_finish = 1'b0;
      step();
      chk("t5_busy_low", f_bus.busy, 1'b0);

      // Reset during a read wait, then a stray strobe; RR restarts at index 0
      r_bus.req_valid = 3'b010;
      r_bus.req_adr[32 +: 32] = 32'h0000_0400;
      step();
      chk("t6_grant", r_bus.req_grant, 3'b010);
      r_bus.req_valid = 3'b000;
      step();
      chk("t6_rd_req", r_bus.mem_read_req, 1'b1);
      rst = 1'b1;
      step();
      chk("t6_rd_req_after_rst", r_bus.mem_read_req, 1'b0);
      chk("t6_busy_after_rst", r_bus.busy, 1'b0);
      rst = 1'b0;
      r_bus.mem_read_valid = 1'b1;
      r_bus.mem_read_data = 32'h0000_0055;
      step();
      chk("t6_no_done", r_bus.rsp_done, 3'b000);
      chk("t6_no_rdata", r_bus.rsp_rdata, 32'h0);
      r_bus.mem_read_valid = 1'b0;
      r_bus.req_valid = 3'b111;
      step();
      chk("t6_rr_restart", r_bus.req_grant, 3'b001);
      r_bus.req_valid = 3'b000;
      step();
      r_bus.mem_read_valid = 1'b1;
      step();
      chk("t6_done", r_bus.rsp_done, 3'b001);
      chk("t6_rdata", r_bus.rsp_rdata, 32'h0000_0055);
      r_bus.mem_read_valid = 1'b0;
      step();
      chk("t6_idle", r_bus.busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Parametrised N-requester arbiter for the shared single-port memory bus. It generalises the fixed i-fetch / d-read / d-write sharing to NUM_REQ requesters (for example instruction fetch, data load/store and a future DMA engine). It supports fixed-priority or round-robin selection, one outstanding transaction, and a per-transaction timeout. It sits between the CPU pipeline stages and the memory/IO fabric.

Parameters:
NUM_REQ, 3, number of requester ports (2..8)
ADR_W, 32, address width
DATA_W, 32, data width
ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
TIMEOUT, 255, wait-cycle limit before abort; 0 disables timeout

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  request pending per requester; held until req_grant
req_we  in  NUM_REQ  1 = write, 0 = read
req_w  in  NUM_REQ  word access
req_hw  in  NUM_REQ  halfword access (req_w=0, req_hw=0 means byte)
req_adr  in  NUM_REQ*ADR_W  flattened addresses; requester i at [i*ADR_W +: ADR_W]
req_wdata  in  NUM_REQ*DATA_W  flattened write data
req_grant  out  NUM_REQ  one-cycle accept pulse, one-hot
rsp_done  out  NUM_REQ  one-cycle completion pulse, one-hot
rsp_err  out  NUM_REQ  asserted with rsp_done on timeout abort
rsp_rdata  out  DATA_W  read data; valid when rsp_done is high
busy  out  1  transaction outstanding
mem_read_req  out  1  read request, level
mem_read_w  out  1  read size word
mem_read_hw  out  1  read size halfword
mem_read_adr  out  ADR_W  read address
mem_read_valid  in  1  read completion strobe
mem_read_data  in  DATA_W  read data
mem_write_req  out  1  write request, level
mem_write_w  out  1  write size word
mem_write_hw  out  1  write size halfword
mem_write_adr  out  ADR_W  write address
mem_write_data  out  DATA_W  write data
mem_write_finish  in  1  write completion strobe

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE. All outputs 0. RR pointer = NUM_REQ-1, so index 0 wins first. Timeout counter = 0.
- Reset mid-transaction: the transaction is dropped, with no rsp_done. mem_*_req is low from the cycle after the reset edge.
- State machine: IDLE, WAIT, RESP.
- IDLE:
  - Combinationally pick the winner from req_valid. Fixed mode: lowest index wins. RR mode: first set bit searching from pointer+1, wrapping modulo NUM_REQ.
  - At the edge, if any request is present: latch the winner's we/w/hw/adr/wdata, register req_grant[winner]=1 for one cycle, enter WAIT, and update the RR pointer to the winner.
- WAIT:
  - mem_read_req (we=0) or mem_write_req (we=1) is held high from the first WAIT cycle, i.e. the same cycle as the grant pulse. Address, size and data are stable throughout.
  - The completion strobe is mem_read_valid for reads and mem_write_finish for writes. The strobe of the other type is ignored.
  - On completion at cycle C: enter RESP. Capture rsp_rdata from mem_read_data on reads; set rsp_rdata=0 on writes.
  - Timeout: the counter increments each WAIT cycle. When it reaches TIMEOUT with no completion, enter RESP with rsp_err set and rsp_rdata=0.
  - Completion in the same cycle as the timeout counts as a normal completion (no error).
- RESP (exactly one cycle):
  - rsp_done[owner]=1; rsp_err[owner] as determined in WAIT.
  - mem_*_req is low.
  - Next state is IDLE; the counter clears.
- Latency:
  - req_valid seen in IDLE at cycle T gives grant at T+1.
  - Strobe at C gives rsp_done at C+1.
  - Earliest next grant is C+3 (IDLE at C+2, arbitration, grant at C+3). Back-to-back zero-wait transfers therefore take 4 cycles each.
- req_valid changes while not in IDLE do not affect the current transaction. The requester must drop req_valid the cycle after req_grant, or it is treated as a new request.
- Completion strobes while in IDLE or RESP are ignored.
- busy = (state != IDLE).
- At most one bit of req_grant, rsp_done and rsp_err is ever set.

Decomposition:
- Package mem_arb_pkg holds the state encoding (IDLE/WAIT/RESP), ARB_MODE constants (ARB_FIXED=0, ARB_RR=1) and the index-width function clog2.
- One sub-module, arb_picker: combinational winner select (fixed / RR from pointer), outputting a one-hot grant and a binary index.

Test Plan:
1. NUM_REQ=3, fixed mode. req_valid=3'b110 in IDLE, req1 read at 0x100, mem_read_valid 2 cycles later with data 0xDEADBEEF -> req_grant=3'b010 at T+1; mem_read_adr=0x100 held; rsp_done=3'b010 with rsp_rdata=0xDEADBEEF one cycle after the strobe.
2. RR mode, all three requesters continuously valid, zero-wait memory -> grant order 0,1,2,0,1,2 with a grant every 4 cycles.
3. Fixed mode, req0 and req2 continuously valid -> req0 always wins; req2 is never granted.
4. TIMEOUT=4, write with no mem_write_finish -> mem_write_req high for 4 cycles, then rsp_done and rsp_err for the owner with rsp_rdata=0, busy low the following cycle.
5. TIMEOUT=4, mem_write_finish in the same cycle the counter reaches 4 -> rsp_done with rsp_err=0.
6. rst asserted during WAIT of a read, then a stray mem_read_valid -> no rsp_done; mem_read_req=0 the cycle after rst; the next grant goes to index 0 in RR mode.
